// File: rtl/ctrl_poll_scheduler.sv
// ctrl_poll_scheduler
// Once per video frame, latches both game pads, clocks 16 bits out of the
// shared serial bus, and samples the NES and SNES data lines in parallel.
// A sticky arbiter picks which pad owns the game inputs, and the owner's
// decoded 12-button report is published with a one-cycle poll_valid pulse.
//
// Timing, where a frame_tick high in cycle 0 starts the poll:
//   cycles 1 .. L                  ctrl_latch high
//   next 32*H cycles               16 x (H cycles clk low, H cycles clk high)
//   cycle  L + 32*H + 1            DONE: poll_valid high, new report visible
module ctrl_poll_scheduler #(
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_CYCLES  = 150
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        nes_data,
    input  logic        snes_data,
    output logic        ctrl_latch,
    output logic        ctrl_clk,
    output logic [11:0] buttons,
    output logic        owner,
    output logic        poll_valid,
    output logic        busy,
    output logic        overrun
);

    // One phase counter serves both the latch phase and each clock half.
    localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLK_LO,
        S_CLK_HI,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [15:0]      r_nes_sr;
    logic [15:0]      r_snes_sr;
    logic [11:0]      r_buttons;
    logic             r_owner;
    logic             r_overrun;

    // Decoded-from-state controls produced by the FSM.
    logic             w_latch;
    logic             w_clk;
    logic             w_busy;
    logic             w_poll_valid;
    logic             w_phase_end;
    logic             w_sample;
    logic             w_bit_inc;
    logic             w_publish;

    // Decode and arbitration results.
    logic [11:0]      w_nes_dec;
    logic [11:0]      w_snes_dec;
    logic             w_nes_any;
    logic             w_snes_any;
    logic             w_owner_next;
    logic             w_unused_bits;

    // State register; reset from any state returns to IDLE, aborting a poll.
    always_ff @(posedge clk) begin
        // NOTE: every sequential block uses non-blocking assignments so all
        // registers see pre-edge values, independent of block ordering.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_clk        = 1'b0;
        w_busy       = 1'b1;
        w_poll_valid = 1'b0;
        w_phase_end  = 1'b0;
        w_sample     = 1'b0;
        w_bit_inc    = 1'b0;
        w_publish    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (frame_tick) begin
                    w_next_state = S_LATCH;
                end
            end

            S_LATCH: begin
                w_latch = 1'b1;
                if (r_cnt == LATCH_LAST) begin
                    w_phase_end  = 1'b1;
                    w_next_state = S_CLK_LO;
                end
            end

            S_CLK_LO: begin
                // Data is captured at the end of the low half, just before
                // the rising edge that advances the pads' shift registers.
                if (r_cnt == HALF_LAST) begin
                    w_phase_end  = 1'b1;
                    w_sample     = 1'b1;
                    w_next_state = S_CLK_HI;
                end
            end

            S_CLK_HI: begin
                w_clk = 1'b1;
                if (r_cnt == HALF_LAST) begin
                    w_phase_end = 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_publish    = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_bit_inc    = 1'b1;
                        w_next_state = S_CLK_LO;
                    end
                end
            end

            S_DONE: begin
                w_poll_valid = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Phase counter: restarts at every phase boundary and rests at zero
    // outside the timed phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_phase_end || (r_state == S_IDLE) || (r_state == S_DONE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bit index: cleared during the latch phase so the first clock is k=0;
    // only advanced after a non-final bit, so it never wraps past 15.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit <= '0;
        end else if (r_state == S_LATCH) begin
            r_bit <= '0;
        end else if (w_bit_inc) begin
            r_bit <= r_bit + 1'b1;
        end
    end

    // Sample both serial lines into bit k of their shift registers.
    always_ff @(posedge clk) begin
        // NOTE: these capture registers are reset too; they feed the
        // published report, so they must never carry power-up garbage.
        if (reset) begin
            r_nes_sr  <= '0;
            r_snes_sr <= '0;
        end else if (w_sample) begin
            r_nes_sr[r_bit]  <= nes_data;
            r_snes_sr[r_bit] <= snes_data;
        end
    end

    // Decode active-low samples into the common 12-button layout and decide
    // the owner. NES order is A,B,Select,Start,Up,Down,Left,Right; it has no
    // Y/X/L/R. SNES order already matches the report layout.
    always_comb begin
        w_nes_dec     = '0;
        w_nes_dec[8]  = ~r_nes_sr[0];
        w_nes_dec[0]  = ~r_nes_sr[1];
        w_nes_dec[2]  = ~r_nes_sr[2];
        w_nes_dec[3]  = ~r_nes_sr[3];
        w_nes_dec[4]  = ~r_nes_sr[4];
        w_nes_dec[5]  = ~r_nes_sr[5];
        w_nes_dec[6]  = ~r_nes_sr[6];
        w_nes_dec[7]  = ~r_nes_sr[7];

        w_snes_dec    = ~r_snes_sr[11:0];

        w_nes_any     = |w_nes_dec;
        w_snes_any    = |w_snes_dec;

        // Ownership is sticky: it only moves when exactly one pad is active.
        w_owner_next  = r_owner;
        if (w_nes_any && !w_snes_any) begin
            w_owner_next = 1'b0;
        end else if (w_snes_any && !w_nes_any) begin
            w_owner_next = 1'b1;
        end
    end

    // Trailing bits are clocked out of the pads but carry no buttons.
    assign w_unused_bits = ^{r_nes_sr[15:8], r_snes_sr[15:12]};

    // Publish the report on the edge entering DONE, so it is visible in the
    // same cycle as poll_valid. A zero report is still published.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner   <= 1'b0;
            r_buttons <= '0;
        end else if (w_publish) begin
            r_owner   <= w_owner_next;
            r_buttons <= w_owner_next ? w_snes_dec : w_nes_dec;
        end
    end

    // Flag a frame_tick that lands while a poll is in progress (DONE included).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= frame_tick && w_busy;
        end
    end

    assign ctrl_latch = w_latch;
    assign ctrl_clk   = w_clk;
    assign busy       = w_busy;
    assign poll_valid = w_poll_valid;
    assign buttons    = r_buttons;
    assign owner      = r_owner;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ctrl_poll_scheduler.sv
// tb_ctrl_poll_scheduler
// Directed polls with hand-computed expectations, plus a cycle-level model
// that describes the poll by its position within the frame (plain offset
// arithmetic) and is compared with the DUT outputs on every cycle.
module tb_ctrl_poll_scheduler;

    localparam int L        = 4;
    localparam int H        = 2;
    localparam int CLK_END  = L + 32 * H;     // last serial-clock cycle (68)
    localparam int DONE_POS = CLK_END + 1;    // poll_valid cycle (69)

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        nes_data;
    logic        snes_data;
    logic        ctrl_latch;
    logic        ctrl_clk;
    logic [11:0] buttons;
    logic        owner;
    logic        poll_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    ctrl_poll_scheduler #(
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .nes_data   (nes_data),
        .snes_data  (snes_data),
        .ctrl_latch (ctrl_latch),
        .ctrl_clk   (ctrl_clk),
        .buttons    (buttons),
        .owner      (owner),
        .poll_valid (poll_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int nes_map [8] = '{8, 0, 2, 3, 4, 5, 6, 7};   // NES bit k -> report bit

    bit          m_active;
    int          m_pos;        // cycles since the starting tick
    logic [15:0] m_nes_s;
    logic [15:0] m_snes_s;
    logic [11:0] m_buttons;
    bit          m_owner;
    bit          m_ov;

    function automatic logic [11:0] nes_report(input logic [15:0] samp);
        logic [11:0] rep = '0;
        for (int k = 0; k < 8; k++) rep[nes_map[k]] = ~samp[k];
        return rep;
    endfunction

    always @(posedge clk) begin : model
        int j;
        logic [11:0] n;
        logic [11:0] s;
        if (reset) begin
            m_active  = 0;
            m_pos     = 0;
            m_owner   = 0;
            m_buttons = '0;
            m_ov      = 0;
            m_nes_s   = '0;
            m_snes_s  = '0;
        end else begin
            m_ov = frame_tick && m_active;
            if (m_active) begin
                if (m_pos > L && m_pos <= CLK_END) begin
                    j = m_pos - L - 1;
                    if (j % (2 * H) == H - 1) begin
                        m_nes_s[j / (2 * H)]  = nes_data;
                        m_snes_s[j / (2 * H)] = snes_data;
                    end
                end
                m_pos++;
                if (m_pos == DONE_POS) begin
                    n = nes_report(m_nes_s);
                    s = ~m_snes_s[11:0];
                    if ((|n) && !(|s)) m_owner = 0;
                    else if ((|s) && !(|n)) m_owner = 1;
                    m_buttons = m_owner ? s : n;
                end else if (m_pos > DONE_POS) begin
                    m_active = 0;
                    m_pos    = 0;
                end
            end else if (frame_tick) begin
                m_active = 1;
                m_pos    = 1;
            end
        end
    end

    bit chk_en = 0;

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit in_clk;
        if (chk_en) begin
            in_clk = m_active && m_pos > L && m_pos <= CLK_END;
            check("latch", 32'(ctrl_latch), 32'(m_active && m_pos >= 1 && m_pos <= L));
            check("sclk", 32'(ctrl_clk), 32'(in_clk && ((m_pos - L - 1) % (2 * H)) >= H));
            check("busy", 32'(busy), 32'(m_active));
            check("poll_valid", 32'(poll_valid), 32'(m_active && m_pos == DONE_POS));
            check("overrun", 32'(overrun), 32'(m_ov));
            check("buttons", 32'(buttons), 32'(m_buttons));
            check("owner", 32'(owner), 32'(m_owner));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        int          pv_first;
        int          pv_n;
        int          ov_first;
        int          ov_n;
        int          rises;
        int          lat_first;
        int          lat_n;
        int          overlap;
        logic [11:0] btn;
        logic        own;
        logic [11:0] snap_btn;
        logic        snap_own;
        logic        snap_latch;
        logic        snap_clk;
        logic        snap_busy;
        logic        snap_pv;
    } res_t;

    // Runs ncyc cycles starting at posedge+1; tick in cycle 0 (and tick2),
    // a one-cycle reset in rst_cyc, pad lines driven per bit window.
    task automatic run_seq(input logic [15:0] nes_p, input logic [15:0] snes_p,
                           input int tick2, input int rst_cyc, input int ncyc,
                           input int snap_cyc, output res_t r);
        int   start = 0;
        int   pos;
        int   k;
        bit   in_win;
        logic prev_clk = 1'b0;
        r = '{pv_first: -1, pv_n: 0, ov_first: -1, ov_n: 0, rises: 0,
              lat_first: -1, lat_n: 0, overlap: 0, btn: '0, own: 1'b0,
              snap_btn: '0, snap_own: 1'b0, snap_latch: 1'b0, snap_clk: 1'b0,
              snap_busy: 1'b0, snap_pv: 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            frame_tick = (c == 0) || (c == tick2);
            reset      = (c == rst_cyc);
            if (c == tick2 && rst_cyc >= 0 && tick2 > rst_cyc) start = tick2;
            pos    = c - start;
            in_win = pos > L && pos <= CLK_END;
            k      = in_win ? (pos - L - 1) / (2 * H) : 0;
            nes_data  = in_win ? ~nes_p[k]  : 1'b1;
            snes_data = in_win ? ~snes_p[k] : 1'b1;
            @(negedge clk);
            if (ctrl_clk && !prev_clk) r.rises++;
            prev_clk = ctrl_clk;
            if (ctrl_latch) begin
                if (r.lat_n == 0) r.lat_first = c;
                r.lat_n++;
            end
            if (ctrl_latch && ctrl_clk) r.overlap++;
            if (poll_valid) begin
                if (r.pv_n == 0) r.pv_first = c;
                r.pv_n++;
                r.btn = buttons;
                r.own = owner;
            end
            if (overrun) begin
                if (r.ov_n == 0) r.ov_first = c;
                r.ov_n++;
            end
            if (c == snap_cyc) begin
                r.snap_btn   = buttons;
                r.snap_own   = owner;
                r.snap_latch = ctrl_latch;
                r.snap_clk   = ctrl_clk;
                r.snap_busy  = busy;
                r.snap_pv    = poll_valid;
            end
            @(posedge clk);
            #1;
        end
        frame_tick = 1'b0;
        reset      = 1'b0;
        nes_data   = 1'b1;
        snes_data  = 1'b1;
    endtask

    res_t r;

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        nes_data   = 1'b1;
        snes_data  = 1'b1;

        // Test 1: reset with random inputs, then idle.
        @(posedge clk);
        #1;
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            nes_data   = 1'($urandom_range(0, 1));
            snes_data  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_outputs", {17'd0, ctrl_latch, ctrl_clk, buttons, owner, poll_valid, busy, overrun}, 32'd0);
            @(posedge clk);
            #1;
        end
        reset      = 1'b0;
        frame_tick = 1'b0;
        nes_data   = 1'b1;
        snes_data  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_bus", {29'd0, ctrl_latch, ctrl_clk, busy}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Test 2: NES A pressed.
        run_seq(16'h0001, 16'h0000, -1, -1, 71, 70, r);
        check("t2_pv_cycle", r.pv_first, 69);
        check("t2_pv_count", r.pv_n, 1);
        check("t2_rises", r.rises, 16);
        check("t2_latch_first", r.lat_first, 1);
        check("t2_latch_len", r.lat_n, 4);
        check("t2_overlap", r.overlap, 0);
        check("t2_buttons", 32'(r.btn), 32'h100);
        check("t2_owner", 32'(r.own), 0);
        check("t2_busy_after", 32'(r.snap_busy), 0);

        // Test 3: SNES Start + R pressed.
        run_seq(16'h0000, 16'h0808, -1, -1, 71, 70, r);
        check("t3_pv_cycle", r.pv_first, 69);
        check("t3_rises", r.rises, 16);
        check("t3_buttons", 32'(r.btn), 32'h808);
        check("t3_owner", 32'(r.own), 1);

        // Test 4: both pads active keeps owner; then both idle.
        run_seq(16'h0010, 16'h0020, -1, -1, 71, 70, r);
        check("t4a_buttons", 32'(r.btn), 32'h020);
        check("t4a_owner", 32'(r.own), 1);
        run_seq(16'h0000, 16'h0000, -1, -1, 71, 70, r);
        check("t4b_pv_count", r.pv_n, 1);
        check("t4b_buttons", 32'(r.btn), 32'h000);
        check("t4b_owner", 32'(r.own), 1);

        // Ignored trailing bits on both pads count as no press.
        run_seq(16'hFF00, 16'hF000, -1, -1, 71, 70, r);
        check("tail_buttons", 32'(r.btn), 32'h000);
        check("tail_owner", 32'(r.own), 1);

        // Test 5: second tick while busy.
        run_seq(16'h0000, 16'h0000, 30, -1, 71, 70, r);
        check("t5_ov_cycle", r.ov_first, 31);
        check("t5_ov_count", r.ov_n, 1);
        check("t5_pv_cycle", r.pv_first, 69);
        check("t5_pv_count", r.pv_n, 1);
        check("t5_busy_70", 32'(r.snap_busy), 0);

        // Test 6: reset mid-poll, then a fresh poll.
        run_seq(16'h0000, 16'h0808, 25, 20, 96, 21, r);
        check("t6_snap_latch", 32'(r.snap_latch), 0);
        check("t6_snap_clk", 32'(r.snap_clk), 0);
        check("t6_snap_busy", 32'(r.snap_busy), 0);
        check("t6_snap_pv", 32'(r.snap_pv), 0);
        check("t6_snap_buttons", 32'(r.snap_btn), 0);
        check("t6_snap_owner", 32'(r.snap_own), 0);
        check("t6_pv_cycle", r.pv_first, 94);
        check("t6_pv_count", r.pv_n, 1);
        check("t6_buttons", 32'(r.btn), 32'h808);
        check("t6_owner", 32'(r.own), 1);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_poll_scheduler.md
Name: ctrl_poll_scheduler

Overview:
Sequences the shared controller serial bus once per video frame. It generates the latch and clock pulses that drive both the NES port and the SNES PMOD port, and shifts in both serial data lines in parallel. A sticky arbiter decides which controller owns the game inputs, and the block presents one decoded 12-button report to the game logic. It sits between the pad pins and the player/game-state logic, triggered by the VGA frame-start tick.

Parameters:
LATCH_CYCLES, 300, number of clk cycles ctrl_latch is held high per poll (>=1)
HALF_CYCLES, 150, number of clk cycles in each low phase and each high phase of ctrl_clk (>=1)

Ports:
clk  input  1  system clock (sole clock domain)
reset  input  1  synchronous reset, active-high
frame_tick  input  1  one-cycle pulse that starts a poll
nes_data  input  1  NES serial data, active-low (0 = pressed)
snes_data  input  1  SNES serial data, active-low (0 = pressed)
ctrl_latch  output  1  latch pulse, shared by both ports
ctrl_clk  output  1  serial clock, shared by both ports, idles low
buttons  output  12  owner's report: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R; 1 = pressed
owner  output  1  0 = NES owns outputs, 1 = SNES owns outputs
poll_valid  output  1  one-cycle pulse when buttons/owner update
busy  output  1  high whenever state != IDLE
overrun  output  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (synchronous, all regs): state=IDLE; ctrl_latch=0, ctrl_clk=0, buttons=0, owner=0, poll_valid=0, busy=0, overrun=0; shift regs and counters=0. Reset mid-poll aborts the poll: no partial report is published and no clock pulse completes.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
- IDLE: frame_tick=1 -> LATCH next cycle. Otherwise stay in IDLE.
- LATCH: ctrl_latch=1 for exactly LATCH_CYCLES cycles, then -> CLK_LO with bit index k=0.
- CLK_LO: ctrl_clk=0 for HALF_CYCLES cycles. On the last cycle, sample nes_data and snes_data into bit k of the respective 16-bit shift regs, then -> CLK_HI.
- CLK_HI: ctrl_clk=1 for HALF_CYCLES cycles. Then: if k==15 -> DONE; else k<=k+1 and -> CLK_LO.
- Each poll produces exactly 16 ctrl_clk rising edges. ctrl_latch and ctrl_clk are never high together.
- DONE (1 cycle): poll_valid=1; buttons/owner update (registered, visible the same cycle as poll_valid); -> IDLE.
- Decode, pressed = ~sample:
  - SNES bits k0..k11 map directly to buttons[0..11]. k12..k15 are ignored.
  - NES: k0 A->[8], k1 B->[0], k2 Select->[2], k3 Start->[3], k4..k7 -> [4..7]. Y/X/L/R = 0. k8..k15 are ignored.
- Arbitration, evaluated in DONE (nes_any/snes_any = OR of that controller's decoded 12 bits):
  - nes_any & !snes_any -> owner=0.
  - snes_any & !nes_any -> owner=1.
  - Both pressed or neither pressed -> owner unchanged.
  - buttons = decoded report of the new owner. The report is published even when all bits are zero.
- Latency: with frame_tick high in cycle 0, poll_valid is high in cycle LATCH_CYCLES + 32*HALF_CYCLES + 1.
- frame_tick while busy: ignored for sequencing (no restart, no queueing); overrun=1 the next cycle. frame_tick in DONE counts as busy.
- Counters are sized to hold max(LATCH_CYCLES, HALF_CYCLES) - 1. Bit index is 4 bits, with no wrap beyond 15.

Test Plan:
1. Assert reset for 3 cycles with random inputs -> all outputs 0, busy=0, state IDLE. Hold idle 10 cycles -> ctrl_latch and ctrl_clk stay 0.
2. LATCH_CYCLES=4, HALF_CYCLES=2; tick at cycle 0; NES drives 0 only at k0; SNES stays high -> ctrl_latch high cycles 1..4; exactly 16 ctrl_clk rising edges; poll_valid only at cycle 69; buttons=12'h100, owner=0.
3. Same params; SNES drives 0 at k3 and k11; NES stays high -> buttons=12'h808, owner=1, poll_valid at 69.
4. Following test 3: NES 0 at k4 (Up) and SNES 0 at k5 (Down) in the same poll -> owner stays 1, buttons=12'h020. Next poll with both lines high -> owner stays 1, buttons=12'h000.
5. Tick at cycle 0 plus a second tick at cycle 30 -> overrun=1 only at cycle 31; poll timing unchanged (poll_valid at 69 only); busy=0 at cycle 70.
6. After test 3 (owner=1), start a poll and assert reset at cycle 20 for 1 cycle -> cycle 21: ctrl_latch=0, ctrl_clk=0, busy=0, buttons=0, owner=0, no poll_valid. A tick at cycle 25 -> full poll, poll_valid at cycle 94.
